// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, functs,
// ALU configuration codes and datapath mux selects.
package mc_ctrl_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned CONF_W = 5;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_EX_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_R, S_WB_I, S_WB_MEM, S_EX_BR, S_EX_J, S_EX_JR
  } state_e;

  // Which rule the ALU-configuration decoder applies in the current state
  typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_SUB} alu_class_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0b;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;
  localparam logic [OP_W-1:0] FN_JALR = 6'h09;
  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2a;
  localparam logic [OP_W-1:0] FN_SLTU = 6'h2b;

  localparam logic [CONF_W-1:0] ALU_AND = 5'b00000;
  localparam logic [CONF_W-1:0] ALU_OR  = 5'b00001;
  localparam logic [CONF_W-1:0] ALU_ADD = 5'b00010;
  localparam logic [CONF_W-1:0] ALU_SUB = 5'b00110;
  localparam logic [CONF_W-1:0] ALU_SLT = 5'b00111;
  localparam logic [CONF_W-1:0] ALU_NOR = 5'b01000;
  localparam logic [CONF_W-1:0] ALU_XOR = 5'b01001;
  localparam logic [CONF_W-1:0] ALU_SLL = 5'b01010;
  localparam logic [CONF_W-1:0] ALU_SRL = 5'b10000;
  localparam logic [CONF_W-1:0] ALU_SRA = 5'b10001;

  localparam logic [SEL_W-1:0] REGDST_RT     = 2'b00;
  localparam logic [SEL_W-1:0] REGDST_RD     = 2'b01;
  localparam logic [SEL_W-1:0] REGDST_RA     = 2'b10;
  localparam logic [SEL_W-1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] MEMTOREG_MDR  = 2'b01;
  localparam logic [SEL_W-1:0] MEMTOREG_PC   = 2'b10;
  localparam logic [SEL_W-1:0] SRCA_PC       = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_REG      = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_SHAMT    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_REG      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR     = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM      = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2  = 2'b11;
  localparam logic [SEL_W-1:0] PCSRC_ALU     = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP    = 2'b10;
  localparam logic [SEL_W-1:0] PCSRC_REG     = 2'b11;

  function automatic logic is_shift(input logic [OP_W-1:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

  function automatic logic is_r_alu(input logic [OP_W-1:0] funct);
    case (funct)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_conf_dec.sv
// Maps the controller's ALU rule class plus OpCode/Funct onto the ALU's
// own ALUConf/Sign encoding.
module mc_alu_conf_dec
  import mc_ctrl_pkg::*;
(
  input  alu_class_e        state_class,
  input  logic [5:0]        op_code,
  input  logic [5:0]        funct,
  output logic [4:0]        alu_conf,
  output logic              sign
);

  always_comb begin
    alu_conf = ALU_ADD;
    sign     = 1'b1;
    case (state_class)
      CLS_SUB: alu_conf = ALU_SUB;
      CLS_R: begin
        sign = (funct != FN_SLTU);
        case (funct)
          FN_SUB, FN_SUBU: alu_conf = ALU_SUB;
          FN_AND:          alu_conf = ALU_AND;
          FN_OR:           alu_conf = ALU_OR;
          FN_XOR:          alu_conf = ALU_XOR;
          FN_NOR:          alu_conf = ALU_NOR;
          FN_SLT, FN_SLTU: alu_conf = ALU_SLT;
          FN_SLL:          alu_conf = ALU_SLL;
          FN_SRL:          alu_conf = ALU_SRL;
          FN_SRA:          alu_conf = ALU_SRA;
          default:         alu_conf = ALU_ADD;
        endcase
      end
      CLS_I: begin
        sign = (op_code != OP_SLTIU);
        case (op_code)
          OP_ANDI:           alu_conf = ALU_AND;
          OP_SLTI, OP_SLTIU: alu_conf = ALU_SLT;
          default:           alu_conf = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU main controller: sequences IF/ID/EX/MEM/WB and drives all
// datapath enables, mux selects and the ALU configuration.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [4:0] ALUConf,
  output logic       Sign,
  output logic       Illegal
);

  state_e     state;
  state_e     next;
  alu_class_e alu_class;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= next;
  end

  mc_alu_conf_dec u_alu_conf_dec (
    .state_class (alu_class),
    .op_code     (OpCode),
    .funct       (Funct),
    .alu_conf    (ALUConf),
    .sign        (Sign)
  );

  // Outputs are forced to their idle values while reset is high so an
  // aborted instruction can never write anything.
  always_comb begin
    next        = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = MEMTOREG_ALU;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    ExtOp       = 1'b1;
    LuiOp       = 1'b0;
    Illegal     = 1'b0;
    alu_class   = CLS_ADD;
    if (!reset) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          next    = S_ID;
        end
        S_ID: begin
          ALUSrcB = SRCB_IMM_SH2;
          case (OpCode)
            OP_LW, OP_SW: next = S_EX_ADDR;
            OP_RTYPE: begin
              if (is_r_alu(Funct))                         next = S_EX_R;
              else if (Funct == FN_JR || Funct == FN_JALR) next = S_EX_JR;
              else                                         Illegal = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI: next = S_EX_I;
            OP_BEQ:       next = S_EX_BR;
            OP_J, OP_JAL: next = S_EX_J;
            default:      Illegal = 1'b1;
          endcase
        end
        S_EX_R: begin
          ALUSrcA   = is_shift(Funct) ? SRCA_SHAMT : SRCA_REG;
          alu_class = CLS_R;
          next      = S_WB_R;
        end
        S_EX_I: begin
          ALUSrcA   = SRCA_REG;
          ALUSrcB   = SRCB_IMM;
          ExtOp     = (OpCode != OP_ANDI);
          LuiOp     = (OpCode == OP_LUI);
          alu_class = CLS_I;
          next      = S_WB_I;
        end
        S_EX_ADDR: begin
          ALUSrcA = SRCA_REG;
          ALUSrcB = SRCB_IMM;
          next    = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          next    = S_WB_MEM;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_WB_R: begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RD;
        end
        S_WB_I:   RegWrite = 1'b1;
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = MEMTOREG_MDR;
        end
        S_EX_BR: begin
          ALUSrcA     = SRCA_REG;
          alu_class   = CLS_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        S_EX_J: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          if (OpCode == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = MEMTOREG_PC;
          end
        end
        S_EX_JR: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_REG;
          if (Funct == FN_JALR) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RD;
            MemtoReg = MEMTOREG_PC;
          end
        end
        default: next = S_IF;
      endcase
    end
  end

endmodule
